// File: rtl/qpsk_symbol_slicer.sv
// qpsk_symbol_slicer
//   Integrate-and-dump symbol slicer for the QPSK demodulator. Each filtered
//   baseband arm is summed over one symbol window. The sign of each sum gives
//   a Gray dibit {i_neg, q_neg}, which is pushed into a small first-word
//   fall-through FIFO. Timing recovery can stretch (slip) or shorten (adv)
//   the next window by one sample.
//
// Ports
//   clk        system clock, one sample per cycle while en=1
//   reset      asynchronous active-high reset
//   en         enable; 0 clears the integrators and aborts the window
//   i_in/q_in  signed LPF outputs, WIDTH bits
//   slip/adv   single-cycle pulses; next window is SPS+1 / SPS-1 samples
//   sym_data   dibit at the FIFO head (holds the last value when empty)
//   sym_valid  FIFO non-empty
//   sym_ready  consumer pops the head when sym_valid=1
//   overflow   sticky flag: a symbol was dropped on a full FIFO
//   ovf_clr    synchronous clear of overflow
//   sym_count  successful FIFO writes, wraps at 2^16
//
// Pending window adjustment:
//   state    | meaning
//   ADJ_NONE | next window is SPS samples
//   ADJ_SLIP | next window is SPS+1 samples
//   ADJ_ADV  | next window is SPS-1 samples

module qpsk_symbol_slicer #(
    parameter int WIDTH      = 32,
    parameter int SPS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] i_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             slip,
    input  logic             adv,
    output logic [1:0]       sym_data,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic [15:0]      sym_count
);

    // Accumulator headroom covers SPS+1 full-scale samples, so no saturation.
    localparam int ACC_W = WIDTH + $clog2(SPS + 2);
    localparam int CNT_W = $clog2(SPS + 2);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] TERM_NOM  = CNT_W'(SPS);
    localparam logic [CNT_W-1:0] TERM_SLIP = CNT_W'(SPS + 1);
    localparam logic [CNT_W-1:0] TERM_ADV  = CNT_W'(SPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ADJ_NONE = 2'd0,
        ADJ_SLIP = 2'd1,
        ADJ_ADV  = 2'd2
    } adj_t;

    adj_t adj_q, adj_d, adj_pulse, adj_eff;

    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] term, term_d;
    logic [ACC_W-1:0] acc_i, acc_q, acc_i_d, acc_q_d;
    logic [ACC_W-1:0] sum_i, sum_q;
    logic             term_hit;
    logic [1:0]       dibit;

    assign sum_i    = acc_i + {{(ACC_W-WIDTH){i_in[WIDTH-1]}}, i_in};
    assign sum_q    = acc_q + {{(ACC_W-WIDTH){q_in[WIDTH-1]}}, q_in};
    assign term_hit = en && (cnt == term - CNT_ONE);
    // A zero sum has a clear sign bit, so it slices as non-negative.
    assign dibit    = {sum_i[ACC_W-1], sum_q[ACC_W-1]};

    // ------------------------------------------------------------------
    // Window control: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adj_q <= ADJ_NONE;
            term  <= TERM_NOM;
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
        end else begin
            adj_q <= adj_d;
            term  <= term_d;
            cnt   <= cnt_d;
            acc_i <= acc_i_d;
            acc_q <= acc_q_d;
        end
    end

    // ------------------------------------------------------------------
    // Window control: next state
    // ------------------------------------------------------------------
    always_comb begin
        adj_pulse = ADJ_NONE;
        adj_eff   = adj_q;
        adj_d     = adj_q;
        term_d    = term;
        cnt_d     = cnt;
        acc_i_d   = acc_i;
        acc_q_d   = acc_q;

        // Simultaneous slip and adv cancel out.
        if (slip && !adv) begin
            adj_pulse = ADJ_SLIP;
        end else if (adv && !slip) begin
            adj_pulse = ADJ_ADV;
        end

        // Only one adjustment is held; later pulses are ignored until it is
        // consumed. A pulse in the terminal cycle still targets the next window.
        if (adj_q == ADJ_NONE) begin
            adj_eff = adj_pulse;
        end

        if (!en) begin
            adj_d   = ADJ_NONE;
            term_d  = TERM_NOM;
            cnt_d   = '0;
            acc_i_d = '0;
            acc_q_d = '0;
        end else if (term_hit) begin
            adj_d   = ADJ_NONE;
            cnt_d   = '0;
            acc_i_d = '0;
            acc_q_d = '0;
            case (adj_eff)
                ADJ_SLIP: term_d = TERM_SLIP;
                ADJ_ADV:  term_d = TERM_ADV;
                default:  term_d = TERM_NOM;
            endcase
        end else begin
            adj_d   = adj_eff;
            cnt_d   = cnt + CNT_ONE;
            acc_i_d = sum_i;
            acc_q_d = sum_q;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [1:0]       last_data;
    logic             empty, full, pop, push_ok, drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = !empty && sym_ready;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign push_ok = term_hit && (!full || pop);
    assign drop    = term_hit && full && !pop;

    assign sym_valid = !empty;
    assign sym_data  = empty ? last_data : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem[k] <= 2'b00;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_data <= 2'b00;
            overflow  <= 1'b0;
            sym_count <= 16'd0;
        end else begin
            if (pop) begin
                last_data <= mem[rd_ptr[PTR_W-1:0]];
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                mem[wr_ptr[PTR_W-1:0]] <= dibit;
                wr_ptr    <= wr_ptr + 1'b1;
                sym_count <= sym_count + 16'd1;
            end
            // A drop in the same cycle as a clear wins.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_symbol_slicer.sv
module tb_qpsk_symbol_slicer;

    localparam int W   = 32;
    localparam int SPS = 16;
    localparam int D   = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0, slip = 1'b0, adv = 1'b0;
    logic                sym_ready = 1'b0, ovf_clr = 1'b0;
    logic signed [W-1:0] i_in = '0, q_in = '0;
    logic [1:0]          sym_data;
    logic                sym_valid, overflow;
    logic [15:0]         sym_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    qpsk_symbol_slicer #(.WIDTH(W), .SPS(SPS), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(rst), .en(en), .i_in(i_in), .q_in(q_in),
        .slip(slip), .adv(adv), .sym_data(sym_data), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .overflow(overflow), .ovf_clr(ovf_clr),
        .sym_count(sym_count)
    );

    // ---------------- reference model ----------------
    longint     m_si, m_sq;
    int         m_n, m_wlen, m_delta, m_cnt;
    bit         m_has, m_ovf, m_pop, m_push, m_drop;
    logic [1:0] m_q[$];
    logic [1:0] m_last, m_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_si = 0; m_sq = 0; m_n = 0; m_wlen = SPS; m_has = 0; m_delta = 0;
            m_q.delete(); m_last = 2'b00; m_ovf = 0; m_cnt = 0;
        end else begin
            m_pop  = (m_q.size() > 0) && sym_ready;
            m_push = 0;
            m_drop = 0;
            m_d    = 2'b00;
            if (en) begin
                m_si += longint'(i_in);
                m_sq += longint'(q_in);
                m_n++;
                if (!m_has && (slip != adv)) begin
                    m_has   = 1;
                    m_delta = slip ? 1 : -1;
                end
                if (m_n == m_wlen) begin
                    m_push = 1;
                    m_d    = {m_si < 0, m_sq < 0};
                    m_si = 0; m_sq = 0; m_n = 0;
                    m_wlen = SPS + (m_has ? m_delta : 0);
                    m_has  = 0;
                end
            end else begin
                m_si = 0; m_sq = 0; m_n = 0; m_has = 0; m_wlen = SPS;
            end
            if (m_pop) m_last = m_q.pop_front();
            if (m_push) begin
                if (m_q.size() < D) begin
                    m_q.push_back(m_d);
                    m_cnt = (m_cnt + 1) % 65536;
                end else begin
                    m_ovf  = 1;
                    m_drop = 1;
                end
            end
            if (ovf_clr && !m_drop) m_ovf = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("valid", {63'd0, sym_valid}, {63'd0, m_q.size() > 0});
        chk("data", {62'd0, sym_data}, {62'd0, (m_q.size() > 0) ? m_q[0] : m_last});
        chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        chk("count", {48'd0, sym_count}, 64'(m_cnt));
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        check_all();
    endtask

    task automatic drive_window(input logic signed [W-1:0] iv, input logic signed [W-1:0] qv);
        i_in = iv;
        q_in = qv;
        repeat (SPS) cyc();
    endtask

    typedef struct {
        logic signed [W-1:0] iv;
        logic signed [W-1:0] qv;
        logic [1:0]          exp;
    } vec_t;

    vec_t tab[7];

    // Window-adjust sequence: records the sample index of the first three writes.
    task automatic seq(input int kind, output int w0, output int w1, output int w2, output int nw);
        logic [15:0] prev;
        int w[3];
        en = 0; sym_ready = 1; cyc();
        en = 1; i_in = 100; q_in = -50;
        prev = sym_count; nw = 0; w = '{0, 0, 0};
        for (int k = 1; k <= 50; k++) begin
            slip = (k == 5) && (kind == 1 || kind == 3);
            adv  = (k == 5) && (kind == 2 || kind == 3);
            cyc();
            slip = 0; adv = 0;
            if (sym_count != prev) begin
                if (nw < 3) w[nw] = k;
                nw++;
                prev = sym_count;
                chk("seq_data", {62'd0, sym_data}, 64'd1);
            end
        end
        w0 = w[0]; w1 = w[1]; w2 = w[2];
    endtask

    int exp_w[4][3];

    initial begin
        int w0, w1, w2, nw, hit;

        tab[0] = '{100, -50, 2'b01};
        tab[1] = '{0, 0, 2'b00};
        tab[2] = '{-1, -1, 2'b11};
        tab[3] = '{-100, 50, 2'b10};
        tab[4] = '{32'sh7fffffff, 32'sh80000000, 2'b01};
        tab[5] = '{32'sh80000000, 32'sh80000000, 2'b11};
        tab[6] = '{32'sh7fffffff, 32'sh7fffffff, 2'b00};
        exp_w[0] = '{16, 32, 48};
        exp_w[1] = '{16, 33, 49};
        exp_w[2] = '{16, 31, 47};
        exp_w[3] = '{16, 32, 48};

        #12;
        chk("rst_valid", {63'd0, sym_valid}, 64'd0);
        chk("rst_data", {62'd0, sym_data}, 64'd0);
        chk("rst_count", {48'd0, sym_count}, 64'd0);
        @(posedge clk); #2; rst = 0;

        // Table: one window per vector, slice checked at the terminal edge.
        sym_ready = 1;
        for (int r = 0; r < 7; r++) begin
            en = 0; cyc();
            en = 1;
            drive_window(tab[r].iv, tab[r].qv);
            chk("tbl_valid", {63'd0, sym_valid}, 64'd1);
            chk("tbl_data", {62'd0, sym_data}, {62'd0, tab[r].exp});
        end

        // Window adjustment: none, slip, adv, slip+adv.
        for (int kind = 0; kind < 4; kind++) begin
            seq(kind, w0, w1, w2, nw);
            chk("seq_w0", 64'(w0), 64'(exp_w[kind][0]));
            chk("seq_w1", 64'(w1), 64'(exp_w[kind][1]));
            chk("seq_w2", 64'(w2), 64'(exp_w[kind][2]));
            chk("seq_nw", 64'(nw), 64'd3);
        end

        // Overflow: five windows with no consumer, then drain in order.
        rst = 1; #1; rst = 0;
        sym_ready = 0; en = 0; cyc(); en = 1;
        for (int r = 0; r < 5; r++) begin
            drive_window(tab[r].iv, tab[r].qv);
            if (r == 3) chk("ovf_before", {63'd0, overflow}, 64'd0);
        end
        chk("ovf_set", {63'd0, overflow}, 64'd1);
        chk("ovf_count", {48'd0, sym_count}, 64'd4);
        en = 0; sym_ready = 1;
        for (int r = 0; r < 4; r++) begin
            chk("drain", {62'd0, sym_data}, {62'd0, tab[r].exp});
            cyc();
        end
        chk("drained", {63'd0, sym_valid}, 64'd0);
        chk("ovf_held", {63'd0, overflow}, 64'd1);
        ovf_clr = 1; cyc(); ovf_clr = 0;
        chk("ovf_clr", {63'd0, overflow}, 64'd0);

        // Async reset at sample 7 of a window.
        sym_ready = 0; en = 0; cyc(); en = 1;
        drive_window(100, -50);
        repeat (6) cyc();
        rst = 1; #1;
        chk("mid_rst_valid", {63'd0, sym_valid}, 64'd0);
        chk("mid_rst_data", {62'd0, sym_data}, 64'd0);
        chk("mid_rst_ovf", {63'd0, overflow}, 64'd0);
        chk("mid_rst_count", {48'd0, sym_count}, 64'd0);
        repeat (3) cyc();
        rst = 0;
        i_in = -100; q_in = -50; hit = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (sym_valid && hit == 0) hit = k;
        end
        chk("rst_first_write", 64'(hit), 64'd16);

        // en dropped at sample 10, restored after 5 cycles.
        en = 0; cyc(); en = 1;
        i_in = 100; q_in = 50;
        repeat (9) cyc();
        en = 0;
        repeat (5) cyc();
        chk("en_no_write", {48'd0, sym_count}, 64'd1);
        chk("en_head", {62'd0, sym_data}, 64'd3);
        en = 1; hit = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (sym_count == 16'd2 && hit == 0) hit = k;
        end
        chk("en_restart", 64'(hit), 64'd16);

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            i_in      = ($urandom_range(0, 7) == 0) ? 0 : $urandom;
            q_in      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 200) - 100 : $urandom;
            en        = ($urandom_range(0, 39) != 0);
            slip      = ($urandom_range(0, 29) == 0);
            adv       = ($urandom_range(0, 29) == 0);
            sym_ready = ($urandom_range(0, 1) == 1);
            ovf_clr   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 799) == 0) begin
                rst = 1; #1; rst = 0;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
